// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM state codes,
// the PC increment and the next-PC select codes.
package fetch_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: fixed-priority mux (JR > J > branch > sequential),
// branch/jump target arithmetic and word-alignment check.
module next_pc_logic
  import fetch_pkg::*;
(
  input  logic        [31:0] pc_plus4_i,
  input  logic               branch_i,
  input  logic               jump_i,
  input  logic               jump_reg_i,
  input  logic signed [31:0] branch_offset_i,
  input  logic        [25:0] jump_index_i,
  input  logic        [31:0] reg_target_i,
  output logic        [31:0] next_pc,
  output logic               misaligned
);

  npc_sel_e           sel;
  logic signed [31:0] br_disp;
  logic        [31:0] br_target;
  logic        [31:0] j_target;

  // Offset is in words; the shift and add both wrap modulo 2^32.
  assign br_disp   = branch_offset_i <<< 2;
  assign br_target = pc_plus4_i + $unsigned(br_disp);
  assign j_target  = {pc_plus4_i[31:28], jump_index_i, 2'b00};

  always_comb begin
    sel = NPC_SEQ;
    if (jump_reg_i)    sel = NPC_JR;
    else if (jump_i)   sel = NPC_J;
    else if (branch_i) sel = NPC_BR;
  end

  always_comb begin
    next_pc = pc_plus4_i;
    case (sel)
      NPC_JR:  next_pc = reg_target_i;
      NPC_J:   next_pc = j_target;
      NPC_BR:  next_pc = br_target;
      default: next_pc = pc_plus4_i;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, req/ack fetch FSM with timeout,
// instruction latch and sticky fetch-error flag.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RegTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [15:0] Imm16,
  output logic        InstrValid,
  output logic [31:0] PCResult,
  output logic [31:0] PCAddResult,
  output logic        FetchErr
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        misaligned;

  assign pc_plus4 = pc_q + PC_INC;

  next_pc_logic u_next_pc (
    .pc_plus4_i      (pc_plus4),
    .branch_i        (Branch),
    .jump_i          (Jump),
    .jump_reg_i      (JumpReg),
    .branch_offset_i ($signed(BranchOffset)),
    .jump_index_i    (JumpIndex),
    .reg_target_i    (RegTarget),
    .next_pc         (next_pc),
    .misaligned      (misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_REQ: begin
        if (IMemAck) begin
          instr_d = IMemData;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_CNT) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_EXEC: begin
        // Acks arriving here are stray and deliberately dropped.
        if (!Stall) begin
          valid_d = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is masked while reset is held so memory never sees a fetch then.
  assign IMemReq     = Reset && (state_q == S_REQ);
  assign IMemAddr    = pc_q;
  assign PCResult    = pc_q;
  assign PCAddResult = pc_plus4;
  assign Instruction = instr_q;
  assign Imm16       = instr_q[15:0];
  assign InstrValid  = valid_q;
  assign FetchErr    = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural model.
module tb_instruction_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic        JumpReg = 1'b0;
  logic [31:0] BranchOffset = '0;
  logic [25:0] JumpIndex = '0;
  logic [31:0] RegTarget = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = '0;
  logic [31:0] Instruction;
  logic [15:0] Imm16;
  logic        InstrValid;
  logic [31:0] PCResult;
  logic [31:0] PCAddResult;
  logic        FetchErr;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (5)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .Branch       (Branch),
    .Jump         (Jump),
    .JumpReg      (JumpReg),
    .BranchOffset (BranchOffset),
    .JumpIndex    (JumpIndex),
    .RegTarget    (RegTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemData     (IMemData),
    .Instruction  (Instruction),
    .Imm16        (Imm16),
    .InstrValid   (InstrValid),
    .PCResult     (PCResult),
    .PCAddResult  (PCAddResult),
    .FetchErr     (FetchErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: "holding" means an instruction has been fetched and not yet retired.
  logic [31:0] m_pc, m_instr;
  bit          m_valid, m_err, m_holding;
  int          m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: evaluate the model from the inputs as the edge sees them.
  task automatic cyc();
    logic [31:0] n_pc, n_instr, tgt, pc4;
    bit          n_valid, n_err, n_holding;
    int          n_wait;
    n_pc = m_pc; n_instr = m_instr; n_valid = m_valid;
    n_err = m_err; n_holding = m_holding; n_wait = m_wait;
    pc4 = m_pc + 32'd4;
    if (!Reset) begin
      n_pc = 32'h0; n_instr = 32'h0; n_valid = 0; n_err = 0; n_holding = 0; n_wait = 0;
    end else if (m_err) begin
      // frozen until reset
    end else if (!m_holding) begin
      if (IMemAck) begin
        n_instr = IMemData; n_valid = 1; n_holding = 1; n_wait = 0;
      end else begin
        n_wait = m_wait + 1;
        if (n_wait >= TIMEOUT) n_err = 1;
      end
    end else if (!Stall) begin
      if (JumpReg)     tgt = RegTarget;
      else if (Jump)   tgt = (pc4 & 32'hF000_0000) | (32'(JumpIndex) << 2);
      else if (Branch) tgt = pc4 + BranchOffset * 32'd4;
      else             tgt = pc4;
      n_valid = 0;
      if (tgt % 4 != 0) n_err = 1;
      else begin
        n_pc = tgt; n_holding = 0;
      end
    end
    @(posedge Clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_valid = n_valid;
    m_err = n_err; m_holding = n_holding; m_wait = n_wait;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("IMemReq",     32'(IMemReq),    32'(Reset && !m_err && !m_holding));
      chk("IMemAddr",    IMemAddr,        m_pc);
      chk("PCResult",    PCResult,        m_pc);
      chk("PCAddResult", PCAddResult,     m_pc + 32'd4);
      chk("Instruction", Instruction,     m_instr);
      chk("Imm16",       32'(Imm16),      m_instr & 32'h0000_FFFF);
      chk("InstrValid",  32'(InstrValid), 32'(m_valid));
      chk("FetchErr",    32'(FetchErr),   32'(m_err));
    end
  end

  task automatic idle();
    Stall = 0; Branch = 0; Jump = 0; JumpReg = 0; IMemAck = 0;
  endtask

  task automatic fetch(input logic [31:0] data);
    IMemAck = 1; IMemData = data;
    cyc();
    IMemAck = 0;
  endtask

  // From S_REQ: fetch, jump-register to pc, fetch again -> executing at pc.
  task automatic exec_at(input logic [31:0] pc);
    fetch(32'h0000_0000);
    JumpReg = 1; RegTarget = pc;
    cyc();
    JumpReg = 0;
    fetch($urandom);
  endtask

  initial begin
    logic [31:0] r;
    int          tmp;
    bit          slow;

    // 1: reset, single-cycle fetch, sequential advance
    idle();
    Reset = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    Reset = 1;
    IMemAck = 1; IMemData = 32'h2008_0005;
    #1;
    chk("t1 req", 32'(IMemReq), 32'h1);
    chk("t1 addr", IMemAddr, 32'h0);
    cyc();
    chk("t1 instr", Instruction, 32'h2008_0005);
    chk("t1 imm16", 32'(Imm16), 32'h0005);
    chk("t1 valid", 32'(InstrValid), 32'h1);
    IMemAck = 0;
    cyc();
    chk("t1 pc", PCResult, 32'h4);

    // 2: branch backwards and forwards from 0x40
    exec_at(32'h40);
    Branch = 1; BranchOffset = 32'hFFFF_FFFC;
    cyc();
    Branch = 0;
    chk("t2 br back", IMemAddr, 32'h34);
    chk("t2 model", m_pc, 32'h34);
    exec_at(32'h40);
    Branch = 1; BranchOffset = 32'h3;
    cyc();
    Branch = 0;
    chk("t2 br fwd", IMemAddr, 32'h50);

    // 3: priority
    exec_at(32'h1000_0000);
    Jump = 1; JumpIndex = 26'h010_0000; Branch = 1; BranchOffset = 32'h10;
    cyc();
    idle();
    chk("t3 j>br", IMemAddr, 32'h1040_0000);
    chk("t3 model", m_pc, 32'h1040_0000);
    fetch(32'h1234_5678);
    JumpReg = 1; RegTarget = 32'h88; Jump = 1;
    cyc();
    idle();
    chk("t3 jr>j", IMemAddr, 32'h88);

    // 4: stall holds everything
    fetch(32'hCAFE_0042);
    Stall = 1; BranchOffset = 32'h5;
    for (int i = 0; i < 5; i++) begin
      Branch = ~Branch;
      cyc();
      chk("t4 instr", Instruction, 32'hCAFE_0042);
      chk("t4 pc", PCResult, 32'h88);
      chk("t4 valid", 32'(InstrValid), 32'h1);
      chk("t4 req", 32'(IMemReq), 32'h0);
    end
    idle();
    cyc();
    chk("t4 release", PCResult, 32'h8C);

    // 5: timeout, late ack, reset recovery, reset discards ack
    for (int i = 0; i < TIMEOUT - 1; i++) cyc();
    chk("t5 pre-timeout", 32'(FetchErr), 32'h0);
    cyc();
    chk("t5 timeout err", 32'(FetchErr), 32'h1);
    chk("t5 req drop", 32'(IMemReq), 32'h0);
    IMemAck = 1; IMemData = 32'hDEAD_BEEF;
    cyc(); cyc();
    chk("t5 late ack", 32'(InstrValid), 32'h0);
    chk("t5 err held", 32'(FetchErr), 32'h1);
    IMemAck = 0; Reset = 0;
    cyc();
    chk("t5 err clr", 32'(FetchErr), 32'h0);
    chk("t5 pc rst", PCResult, 32'h0);
    IMemAck = 1;
    cyc();
    chk("t5 rst drops ack", 32'(InstrValid), 32'h0);
    IMemAck = 0; Reset = 1;

    // 6: misaligned JR, then wrap-around
    exec_at(32'h200);
    JumpReg = 1; RegTarget = 32'h0000_0102;
    cyc();
    chk("t6 misalign err", 32'(FetchErr), 32'h1);
    chk("t6 pc kept", PCResult, 32'h200);
    JumpReg = 0; IMemAck = 1;
    cyc(); cyc();
    chk("t6 err hold pc", PCResult, 32'h200);
    chk("t6 err hold req", 32'(IMemReq), 32'h0);
    idle(); Reset = 0;
    cyc();
    Reset = 1;
    exec_at(32'hFFFF_FFFC);
    cyc();
    chk("t6 wrap addr", IMemAddr, 32'h0);
    chk("t6 wrap err", 32'(FetchErr), 32'h0);

    // Randomized traffic
    slow = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) slow = ($urandom_range(0, 2) == 0);
      if (m_err) Reset = ($urandom_range(0, 3) != 0);
      else       Reset = ($urandom_range(0, 149) != 0);
      Stall   = ($urandom_range(0, 2) == 0);
      Branch  = ($urandom_range(0, 3) == 0);
      Jump    = ($urandom_range(0, 3) == 0);
      JumpReg = ($urandom_range(0, 3) == 0);
      tmp = int'($urandom_range(0, 64)) - 32;
      BranchOffset = tmp;
      JumpIndex = 26'($urandom);
      r = $urandom;
      r[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      RegTarget = r;
      IMemAck  = slow ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 1) == 0);
      IMemData = $urandom;
      cyc();
    end

    idle();
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
